// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizes ps2_clk/ps2_data, deframes 11-bit frames, buffers bytes in a FIFO.
// Build macro PS2_PARITY_CHECK_EN adds odd-parity validation; without it only start/stop bits are checked.
module ps2_rx_fifo #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(10);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_hist;
  logic [SYNC_STAGES-2:0] data_hist;
  logic                   fall;
  logic                   data_bit;
  logic [CNT_W-1:0]       bit_cnt;
  logic [9:0]             shift;
  logic [TMR_W-1:0]       timer;
  logic                   frame_done;
  logic                   frame_ok;
  logic [7:0]             mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   wr_en;
  logic                   drop;
  logic                   pop;

  // Data history is one stage shorter so its newest-but-aligned tap matches the clock edge sample.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_hist  <= '1;
      data_hist <= '1;
    end else begin
      clk_hist  <= {clk_hist[SYNC_STAGES-2:0], ps2_clk};
      data_hist <= {data_hist[SYNC_STAGES-3:0], ps2_data};
    end
  end

  assign fall       = clk_hist[SYNC_STAGES-1] & ~clk_hist[SYNC_STAGES-2];
  assign data_bit   = data_hist[SYNC_STAGES-2];
  assign frame_done = fall && (bit_cnt == LAST_BIT);

  // shift holds start..parity after ten edges; the stop bit is the live sample on the eleventh.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = ~shift[0] & data_bit & (^shift[9:1]);
`else
    frame_ok = ~shift[0] & data_bit;
`endif
  end

  // Bit counter, shift register and partial-frame watchdog.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt <= '0;
      shift   <= '0;
      timer   <= '0;
    end else if (fall) begin
      timer <= '0;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        shift   <= {data_bit, shift[9:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end else if (bit_cnt == '0) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      bit_cnt <= '0;
      timer   <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0]) && (rd_ptr[ADDR_W] != wr_ptr[ADDR_W]);
  assign wr_en = frame_done & frame_ok & ~full;
  assign drop  = frame_done & frame_ok & full;
  assign pop   = ~empty & ~nextdata_n;

  // Overflow set on a drop wins over the clear from a same-cycle pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop)     overflow <= 1'b1;
      else if (pop) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= shift[8:1];
  end

  assign data  = mem[rd_ptr[ADDR_W-1:0]];
  assign ready = ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized bench for ps2_rx_fifo against a queue-based model of received bytes and the overflow flag.
module tb_ps2_rx_fifo;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  logic [7:0] q[$];
  bit         ovf_m;
  int         n_vec = 0;
  int         n_err = 0;
  int         last_lat;

  ps2_rx_fifo #(.ADDR_W(3), .SYNC_STAGES(3), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ready"}, 32'(ready), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, ".data"}, 32'(data), 32'(q[0]));
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic start_b, input logic par_bad,
                            input logic stop_b, input int nbits, input bit pop_at_write);
    logic [10:0] b;
    int h;
    b = {stop_b, (~^d) ^ par_bad, d, start_b};
    h = 6 + int'($urandom_range(0, 6));
    last_lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      repeat (h) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_write) begin
        repeat (2) @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        repeat (h - 3) @(negedge clk);
      end else if (i == 10) begin
        for (int k = 1; k <= h; k++) begin
          @(negedge clk);
          if (ready && last_lat < 0) last_lat = k;
        end
      end else begin
        repeat (h) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (h) @(negedge clk);
  endtask

  // Reference: a write is judged against pre-pop fullness; the pop (if any) applies to the old head.
  task automatic model_frame(input logic [7:0] d, input logic start_b, input logic par_bad,
                             input logic stop_b, input bit popped);
    bit ok;
    bit was_full;
    ok = !start_b && stop_b;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && !par_bad;
`endif
    was_full = (q.size() == 8);
    if (popped && q.size() > 0) begin
      void'(q.pop_front());
      ovf_m = 1'b0;
    end
    if (ok) begin
      if (was_full) ovf_m = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic start_b,
                       input logic par_bad, input logic stop_b, input bit popw);
    send_frame(d, start_b, par_bad, stop_b, 11, popw);
    model_frame(d, start_b, par_bad, stop_b, popw);
    check_state(tag);
  endtask

  task automatic do_pop(input string tag);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (q.size() > 0) begin
      void'(q.pop_front());
      ovf_m = 1'b0;
    end
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) do_pop(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clrn = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    check_state(tag);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int err;
    do_reset("reset");

    // Single frame, ready latency and pop back to empty.
    frame("f1c", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    check("latency_ok", 32'(last_lat >= 1 && last_lat <= 3), 32'd1);
    do_pop("pop1");

    // In-order delivery.
    frame("seq0", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    frame("seq1", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame("seq2", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("seq_pop");

    // Fill to eight, then overflow with a ninth.
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      frame("fill", d, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drain("fill_pop");
    do_pop("pop_empty");

    // Bad parity (build dependent) and bad stop bit.
    frame("badpar", 8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    frame("badstop", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("bad_pop");

    // Partial frame discarded by the watchdog.
    send_frame(8'h2D, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    repeat (TO + 40) @(negedge clk);
    frame("tmo", 8'h2D, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tmo_cnt", 32'(q.size()), 32'd1);
    drain("tmo_pop");

    // Partial frame discarded by reset.
    send_frame(8'h2D, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    do_reset("mid_rst");
    frame("rst2d", 8'h2D, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("rst_pop");

    // Write and pop in the same cycle at occupancy 1.
    frame("sim_a", 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    frame("sim_b", 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("sim_pop");

    // Full FIFO with a same-cycle pop: byte dropped, overflow stays set.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      frame("full", d, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    frame("full_pop", 8'hC4, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("full_drain");

    // Random frames with random errors and random pops.
    for (int i = 0; i < 24; i++) begin
      err = int'($urandom_range(0, 9));
      d = 8'($urandom);
      frame("rnd", d, 1'(err == 0), 1'(err == 2 || err == 3), 1'(err != 1),
            1'(q.size() > 0 && $urandom_range(0, 3) == 0));
      for (int p = int'($urandom_range(0, 2)); p > 0; p--) do_pop("rnd_pop");
    end
    drain("end_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver. Samples the raw ps2_clk/ps2_data lines in the system clock domain, deframes 11-bit scan-code frames and buffers the bytes in a small FIFO.
- Presents a ready/nextdata_n/overflow pop interface to the downstream scan-code-to-ASCII/key-state stage.
- One byte is popped per accepted request.

Parameters:
- ADDR_W, 3, log2 of FIFO depth (depth = 8 entries, all usable).
- SYNC_STAGES, 3, length of the ps2_clk synchronizer/edge-detect history, minimum 3.
- TIMEOUT_CYC, 50000, system clocks without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- nextdata_n  in  1  active-low pop request, sampled at posedge clk.
- data  out  8  byte at FIFO head (valid while ready=1).
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.

Behaviour:
- Reset (clrn=0, async): rd_ptr=wr_ptr=0, bit_cnt=0, shift=0, timer=0, sync history all 1s. Outputs: ready=0, overflow=0, data = mem[0] (don't-care).
- Mid-frame reset discards the partial frame. FIFO contents are lost.
- Sync: ps2_clk shifts into a SYNC_STAGES-bit history each clk. A falling edge is detected when the two oldest bits are 1 then 0, giving 2-3 clk detection latency.
- Frame capture: on each detected falling edge, ps2_data (history-aligned sample) shifts into a 10-bit register, LSB first, and bit_cnt increments 0..9.
- Frame bit order: start(0), d0..d7, parity, stop(1).
- On the edge where bit_cnt==10 (11th bit), evaluate the frame and force bit_cnt to 0 regardless of outcome.
- Frame valid: start==0, stop==1, and XOR(d7..d0, parity)==1 (odd parity); parity checking is subject to the Optional Feature.
- Valid frame, FIFO not full: write mem[wr_ptr]=d, wr_ptr+1 in that clk.
- Valid frame, FIFO full: byte dropped, overflow<=1, pointers unchanged.
- Invalid frame: dropped silently, no flag.
- Watchdog: timer clears on every falling edge and counts while bit_cnt!=0. On reaching TIMEOUT_CYC: bit_cnt<=0, timer<=0, partial frame discarded. Timer is held at 0 while bit_cnt==0.
- Pointers are ADDR_W+1 bits with a wrap MSB.
  - empty = (rd_ptr==wr_ptr).
  - full = same index bits, differing MSB.
  - Natural wrap-around at 2^ADDR_W.
- ready = !empty, registered-pointer derived: a byte written at edge N has ready=1 after edge N.
- data = mem[rd_ptr[ADDR_W-1:0]], combinational from registered state.
- Pop: at posedge clk with ready=1 and nextdata_n=0, rd_ptr+1 and overflow<=0. Pop while empty is ignored.
- Simultaneous write and pop in one clk: both take effect and occupancy is unchanged.
- On a full FIFO with a same-cycle pop, the write is still judged against pre-pop full: byte dropped, overflow set, and overflow stays set because the set wins over the pop-clear.
- Back-to-back pops are allowed every clk while ready.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: validity requires start==0, stop==1 and odd parity, as above.
- Undefined: parity bit ignored; only start==0 and stop==1 are checked.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), 30 µs per half-period -> ready=1 within 3 clk of the 11th falling edge, data=0x1C. Pop with nextdata_n=0 for 1 clk -> ready=0.
- Frames 0x1C, 0xF0 (parity 1), 0x1C with no pops -> popped in order 0x1C, 0xF0, 0x1C; overflow=0 throughout.
- Push 9 valid frames with no pops -> after 8: ready=1, overflow=0. After 9th: overflow=1. Pops return first 8 bytes; overflow=0 after first pop; 9th byte never appears.
- Frame 0x1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: ready stays 0. Without: data=0x1C. Bad stop bit (0) -> dropped in both builds.
- Send 5 bits of a frame, idle > TIMEOUT_CYC, then full frame 0x2D -> only 0x2D is buffered. Same 5 bits then clrn pulse, then 0x2D -> only 0x2D buffered, overflow=0.
- Byte in FIFO at occupancy 1, pop issued in the same clk as a new frame write -> ready remains 1, next data is the new byte.
